fsm_rr_share_ctrl: RTL

Round-robin scheduler that shares one W-bit adder datapath between three requesters (a, b, c). Each granted request adds the requester's operand into that requester's private accumulator (x, y, z). The sequencing FSM has a deliberately unreachable spare encoding that must recover safely, so the block also serves as an fsm extraction/unreachable-state regression target. It sits between the operand sources and the result consumers in the top-level test designs.

---
 rtl/fsm_rr_share_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fsm_rr_share_ctrl.sv
// Round-robin share controller: one W-bit adder time-shared by requesters a/b/c,
// each with a private accumulator (x/y/z). A spare state encoding recovers to IDLE and sets err.
//   state | meaning
//   IDLE  | arbitrate among pending requests, capture owner operand
//   EXEC  | wait out the LAT-cycle datapath latency, grant held
//   WRITE | pulse owner ack, accumulate, advance round-robin pointer
//   (3)   | unreachable spare; recovers to IDLE with sticky err
module fsm_rr_share_ctrl #(
    parameter int           W         = 5,
    parameter int           LAT       = 2,
    parameter logic [W-1:0] RESET_VAL = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_a_i,
    input  logic         req_b_i,
    input  logic         req_c_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic         ack_a_o,
    output logic         ack_b_o,
    output logic         ack_c_o,
    output logic [2:0]   grant_o,
    output logic         busy_o,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic [W-1:0] z_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Held as a raw vector so the spare encoding 3 stays representable.
    logic [1:0]   state_q;
    logic [1:0]   owner_q;
    logic [1:0]   ptr_q;
    logic [2:0]   cnt_q;
    logic [W-1:0] op_q;
    logic [W-1:0] x_q, y_q, z_q;
    logic [2:0]   grant_q;
    logic [2:0]   ack_q;
    logic         busy_q;
    logic         err_q;

    logic [2:0]   req_w;
    logic [1:0]   pick_d;
    logic [W-1:0] opnd_d;

    assign req_w = {req_c_i, req_b_i, req_a_i};

    always_comb begin
        pick_d = 2'd0;
        case (ptr_q)
            2'd1:    pick_d = req_w[1] ? 2'd1 : (req_w[2] ? 2'd2 : 2'd0);
            2'd2:    pick_d = req_w[2] ? 2'd2 : (req_w[0] ? 2'd0 : 2'd1);
            default: pick_d = req_w[0] ? 2'd0 : (req_w[1] ? 2'd1 : 2'd2);
        endcase
        opnd_d = a_i;
        case (pick_d)
            2'd1:    opnd_d = b_i;
            2'd2:    opnd_d = c_i;
            default: opnd_d = a_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 3'd0;
            op_q    <= '0;
            x_q     <= RESET_VAL;
            y_q     <= RESET_VAL;
            z_q     <= RESET_VAL;
            grant_q <= 3'b000;
            ack_q   <= 3'b000;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 3'b000;
            case (state_q)
                IDLE: begin
                    if (|req_w) begin
                        owner_q <= pick_d;
                        op_q    <= opnd_d;
                        grant_q <= 3'b001 << pick_d;
                        cnt_q   <= 3'(LAT - 1);
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 3'd0) begin
                        ack_q   <= grant_q;
                        state_q <= WRITE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                WRITE: begin
                    case (owner_q)
                        2'd0: begin
                            x_q   <= x_q + op_q;
                            ptr_q <= 2'd1;
                        end
                        2'd1: begin
                            y_q   <= y_q + op_q;
                            ptr_q <= 2'd2;
                        end
                        default: begin
                            z_q   <= z_q + op_q;
                            ptr_q <= 2'd0;
                        end
                    endcase
                    grant_q <= 3'b000;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    grant_q <= 3'b000;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack_a_o = ack_q[0];
    assign ack_b_o = ack_q[1];
    assign ack_c_o = ack_q[2];
    assign grant_o = grant_q;
    assign busy_o  = busy_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;
    assign err_o   = err_q;

endmodule
